// File: rtl/decode_step.sv
// +--------------------------------------------------------------------------+
// | decode_step: RV32I decode stage. It accepts one instruction per rising    |
// | edge of the fetch activate signal and issues a registered bundle to the   |
// | execute stage. Define DECODE_M_EXT_EN to accept RV32M encodings.          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module decode_step #(
  parameter int XLEN    = 32,
  parameter int CLASS_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        instruction_i,
  input  logic               decode_activate_i,
  input  logic               execute_working_info_i,
  output logic [4:0]         rs1_addr_o,
  output logic [4:0]         rs2_addr_o,
  input  logic [XLEN-1:0]    rs1_data_i,
  input  logic [XLEN-1:0]    rs2_data_i,
  output logic               decode_working_info_o,
  output logic               execute_activate_o,
  output logic [CLASS_W-1:0] op_class_o,
  output logic [2:0]         funct3_o,
  output logic [6:0]         funct7_o,
  output logic [4:0]         rd_o,
  output logic [XLEN-1:0]    imm_o,
  output logic [XLEN-1:0]    rs1_val_o,
  output logic [XLEN-1:0]    rs2_val_o,
  output logic               illegal_o,
  output logic               is_mext_o,
  output logic               protocol_error_o
);

`ifdef DECODE_M_EXT_EN
  localparam logic M_EN = 1'b1;
`else
  localparam logic M_EN = 1'b0;
`endif

  localparam logic [CLASS_W-1:0] CLS_NONE   = CLASS_W'(0);
  localparam logic [CLASS_W-1:0] CLS_LUI    = CLASS_W'(1);
  localparam logic [CLASS_W-1:0] CLS_AUIPC  = CLASS_W'(2);
  localparam logic [CLASS_W-1:0] CLS_JAL    = CLASS_W'(3);
  localparam logic [CLASS_W-1:0] CLS_JALR   = CLASS_W'(4);
  localparam logic [CLASS_W-1:0] CLS_BRANCH = CLASS_W'(5);
  localparam logic [CLASS_W-1:0] CLS_LOAD   = CLASS_W'(6);
  localparam logic [CLASS_W-1:0] CLS_STORE  = CLASS_W'(7);
  localparam logic [CLASS_W-1:0] CLS_OPIMM  = CLASS_W'(8);
  localparam logic [CLASS_W-1:0] CLS_OP     = CLASS_W'(9);
  localparam logic [CLASS_W-1:0] CLS_FENCE  = CLASS_W'(10);
  localparam logic [CLASS_W-1:0] CLS_SYSTEM = CLASS_W'(11);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_READ   = 3'd2,
    S_STALL  = 3'd3,
    S_ISSUE  = 3'd4
  } state_e;

  state_e             state_q;
  logic               act_q;
  logic [31:0]        instr_q;
  logic [CLASS_W-1:0] cls_q, cls_d;
  logic [XLEN-1:0]    imm_q, imm_d;
  logic               illegal_q, illegal_d;
  logic               mext_q, mext_d;
  logic [XLEN-1:0]    rs1v_q, rs2v_q;
  logic [31:0]        imm32;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic               act_rise;
  logic               issue_go;
  logic [XLEN-1:0]    rs1_cap, rs2_cap;

  assign funct3   = instr_q[14:12];
  assign funct7   = instr_q[31:25];
  assign act_rise = decode_activate_i & ~act_q;
  assign issue_go = ((state_q == S_READ) || (state_q == S_STALL)) && !execute_working_info_i;

  // Register-file addresses are only presented while operands are being fetched.
  assign rs1_addr_o = ((state_q == S_DECODE) || (state_q == S_READ)) ? instr_q[19:15] : 5'd0;
  assign rs2_addr_o = ((state_q == S_DECODE) || (state_q == S_READ)) ? instr_q[24:20] : 5'd0;
  assign rs1_cap    = (instr_q[19:15] == 5'd0) ? '0 : rs1_data_i;
  assign rs2_cap    = (instr_q[24:20] == 5'd0) ? '0 : rs2_data_i;

  assign decode_working_info_o = (state_q != S_IDLE);

  always_comb begin
    cls_d     = CLS_NONE;
    imm32     = 32'd0;
    illegal_d = 1'b0;
    mext_d    = 1'b0;
    if (instr_q[1:0] == 2'b11) begin
      case (instr_q[6:2])
        5'b01101: cls_d = CLS_LUI;
        5'b00101: cls_d = CLS_AUIPC;
        5'b11011: cls_d = CLS_JAL;
        5'b11001: cls_d = CLS_JALR;
        5'b11000: cls_d = CLS_BRANCH;
        5'b00000: cls_d = CLS_LOAD;
        5'b01000: cls_d = CLS_STORE;
        5'b00100: cls_d = CLS_OPIMM;
        5'b01100: cls_d = CLS_OP;
        5'b00011: cls_d = CLS_FENCE;
        5'b11100: cls_d = CLS_SYSTEM;
        default:  cls_d = CLS_NONE;
      endcase
    end
    case (cls_d)
      CLS_LUI, CLS_AUIPC: imm32 = {instr_q[31:12], 12'b0};
      CLS_JAL:    imm32 = {{12{instr_q[31]}}, instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
      CLS_BRANCH: imm32 = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
      CLS_STORE:  imm32 = {{21{instr_q[31]}}, instr_q[30:25], instr_q[11:7]};
      CLS_JALR, CLS_LOAD, CLS_OPIMM, CLS_FENCE, CLS_SYSTEM:
                  imm32 = {{21{instr_q[31]}}, instr_q[30:20]};
      default:    imm32 = 32'd0;
    endcase
    illegal_d = (cls_d == CLS_NONE);
    if (cls_d == CLS_OP) begin
      if (funct7 == 7'b0000001) begin
        illegal_d = !M_EN;
        mext_d    = M_EN;
      end else if (funct7 == 7'b0100000) begin
        illegal_d = !((funct3 == 3'b000) || (funct3 == 3'b101));
      end else if (funct7 != 7'b0000000) begin
        illegal_d = 1'b1;
      end
    end
    // Shift-immediates reuse the funct7 slot, so it must be a legal shift selector.
    if (cls_d == CLS_OPIMM) begin
      if (funct3 == 3'b001)
        illegal_d = (funct7 != 7'b0000000);
      else if (funct3 == 3'b101)
        illegal_d = !((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
    end
  end

  assign imm_d = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q            <= S_IDLE;
      act_q              <= 1'b0;
      instr_q            <= '0;
      cls_q              <= '0;
      imm_q              <= '0;
      illegal_q          <= 1'b0;
      mext_q             <= 1'b0;
      rs1v_q             <= '0;
      rs2v_q             <= '0;
      execute_activate_o <= 1'b0;
      op_class_o         <= '0;
      funct3_o           <= '0;
      funct7_o           <= '0;
      rd_o               <= '0;
      imm_o              <= '0;
      rs1_val_o          <= '0;
      rs2_val_o          <= '0;
      illegal_o          <= 1'b0;
      is_mext_o          <= 1'b0;
      protocol_error_o   <= 1'b0;
    end else begin
      act_q              <= decode_activate_i;
      execute_activate_o <= 1'b0;
      if (act_rise && (state_q != S_IDLE))
        protocol_error_o <= 1'b1;
      if (issue_go) begin
        execute_activate_o <= 1'b1;
        op_class_o         <= cls_q;
        funct3_o           <= funct3;
        funct7_o           <= funct7;
        rd_o               <= instr_q[11:7];
        imm_o              <= imm_q;
        illegal_o          <= illegal_q;
        is_mext_o          <= mext_q;
        rs1_val_o          <= (state_q == S_READ) ? rs1_cap : rs1v_q;
        rs2_val_o          <= (state_q == S_READ) ? rs2_cap : rs2v_q;
      end
      case (state_q)
        S_IDLE: begin
          if (act_rise) begin
            instr_q <= instruction_i;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          cls_q     <= cls_d;
          imm_q     <= imm_d;
          illegal_q <= illegal_d;
          mext_q    <= mext_d;
          state_q   <= S_READ;
        end
        S_READ: begin
          rs1v_q  <= rs1_cap;
          rs2v_q  <= rs2_cap;
          state_q <= execute_working_info_i ? S_STALL : S_ISSUE;
        end
        S_STALL: begin
          if (!execute_working_info_i)
            state_q <= S_ISSUE;
        end
        S_ISSUE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_step.sv
// +--------------------------------------------------------------------------+
// | tb_decode_step: randomized self-checking bench for decode_step with a     |
// | behavioural RV32I decode reference. Honours DECODE_M_EXT_EN.              |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_decode_step;

`ifdef DECODE_M_EXT_EN
  localparam bit M_ON = 1'b1;
`else
  localparam bit M_ON = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] instruction_i = '0;
  logic        decode_activate_i = 1'b0;
  logic        execute_working_info_i = 1'b0;
  logic [4:0]  rs1_addr_o, rs2_addr_o;
  logic [31:0] rs1_data_i, rs2_data_i;
  logic        decode_working_info_o, execute_activate_o;
  logic [3:0]  op_class_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [4:0]  rd_o;
  logic [31:0] imm_o, rs1_val_o, rs2_val_o;
  logic        illegal_o, is_mext_o, protocol_error_o;

  logic [31:0] rf [32];
  logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
  logic [6:0]  f7s [4];
  int          n_err = 0;
  int          n_chk = 0;
  logic        exp_perr = 1'b0;

  typedef struct packed {
    logic [3:0]  cls;
    logic [31:0] imm;
    logic        ill;
    logic        mx;
  } exp_t;

  assign rs1_data_i = rf[rs1_addr_o];
  assign rs2_data_i = rf[rs2_addr_o];

  always #5 clk_i = ~clk_i;

  decode_step dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .instruction_i          (instruction_i),
    .decode_activate_i      (decode_activate_i),
    .execute_working_info_i (execute_working_info_i),
    .rs1_addr_o             (rs1_addr_o),
    .rs2_addr_o             (rs2_addr_o),
    .rs1_data_i             (rs1_data_i),
    .rs2_data_i             (rs2_data_i),
    .decode_working_info_o  (decode_working_info_o),
    .execute_activate_o     (execute_activate_o),
    .op_class_o             (op_class_o),
    .funct3_o               (funct3_o),
    .funct7_o               (funct7_o),
    .rd_o                   (rd_o),
    .imm_o                  (imm_o),
    .rs1_val_o              (rs1_val_o),
    .rs2_val_o              (rs2_val_o),
    .illegal_o              (illegal_o),
    .is_mext_o              (is_mext_o),
    .protocol_error_o       (protocol_error_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    int   f3, f7, v;
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    v  = 0;
    case (ins[6:0])
      7'h37: e.cls = 4'd1;
      7'h17: e.cls = 4'd2;
      7'h6F: e.cls = 4'd3;
      7'h67: e.cls = 4'd4;
      7'h63: e.cls = 4'd5;
      7'h03: e.cls = 4'd6;
      7'h23: e.cls = 4'd7;
      7'h13: e.cls = 4'd8;
      7'h33: e.cls = 4'd9;
      7'h0F: e.cls = 4'd10;
      7'h73: e.cls = 4'd11;
      default: e.cls = 4'd0;
    endcase
    case (e.cls)
      4'd1, 4'd2: v = int'(ins & 32'hFFFFF000);
      4'd3: v = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2 - (ins[31] ? 1048576 : 0);
      4'd5: v = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2 - (ins[31] ? 4096 : 0);
      4'd7: v = ($signed(ins) >>> 25) * 32 + int'(ins[11:7]);
      4'd4, 4'd6, 4'd8, 4'd10, 4'd11: v = $signed(ins) >>> 20;
      default: v = 0;
    endcase
    e.imm = v;
    e.mx  = M_ON && (e.cls == 4'd9) && (f7 == 1);
    e.ill = (e.cls == 4'd0)
         || ((e.cls == 4'd9) && !((f7 == 0) || ((f7 == 32) && (f3 == 0 || f3 == 5)) || (M_ON && f7 == 1)))
         || ((e.cls == 4'd8) && (f3 == 1) && (f7 != 0))
         || ((e.cls == 4'd8) && (f3 == 5) && (f7 != 0) && (f7 != 32));
    return e;
  endfunction

  task automatic chk_bundle(input logic [31:0] ins, input exp_t e);
    chk("op_class", op_class_o, e.cls);
    chk("funct3", funct3_o, ins[14:12]);
    chk("funct7", funct7_o, ins[31:25]);
    chk("rd", rd_o, ins[11:7]);
    chk("imm", imm_o, e.imm);
    chk("rs1_val", rs1_val_o, (ins[19:15] == 5'd0) ? 32'd0 : rf[ins[19:15]]);
    chk("rs2_val", rs2_val_o, (ins[24:20] == 5'd0) ? 32'd0 : rf[ins[24:20]]);
    chk("illegal", illegal_o, e.ill);
    chk("is_mext", is_mext_o, e.mx);
  endtask

  // s: stall cycles from READ, h: cycles activate is held, re: cycle of an extra rising edge (0 = none)
  task automatic run(input logic [31:0] ins, input int s, input int h, input int re);
    exp_t e;
    int   pulses;
    e = model(ins);
    pulses = 0;
    instruction_i = ins;
    decode_activate_i = 1'b1;
    for (int k = 1; k <= s + 6; k++) begin
      @(posedge clk_i); #1;
      if (re > 0 && k == re + 1) exp_perr = 1'b1;
      chk("exec_pulse", execute_activate_o, (k == s + 3));
      chk("working", decode_working_info_o, (k <= s + 3));
      chk("proto_err", protocol_error_o, exp_perr);
      if (execute_activate_o) pulses++;
      if (k <= 2) begin
        chk("rs1_addr", rs1_addr_o, ins[19:15]);
        chk("rs2_addr", rs2_addr_o, ins[24:20]);
      end
      if (k == s + 3 || k == s + 6) chk_bundle(ins, e);
      decode_activate_i = (k < h) || (k == re);
      execute_working_info_i = (k >= 2) && (k <= s + 1);
      if (k == s + 4) instruction_i = $urandom;
    end
    chk("pulse_count", pulses, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_working"}, decode_working_info_o, 0);
    chk({tag, "_exec"}, execute_activate_o, 0);
    chk({tag, "_class"}, op_class_o, 0);
    chk({tag, "_f3f7rd"}, {funct3_o, funct7_o, rd_o}, 0);
    chk({tag, "_imm"}, imm_o, 0);
    chk({tag, "_rs_val"}, rs1_val_o | rs2_val_o, 0);
    chk({tag, "_flags"}, {illegal_o, is_mext_o, protocol_error_o}, 0);
    chk({tag, "_addr"}, {rs1_addr_o, rs2_addr_o}, 0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    ins = $urandom;
    f7s[0] = 7'b0000000;
    f7s[1] = 7'b0100000;
    f7s[2] = 7'b0000001;
    f7s[3] = 7'($urandom);
    if ($urandom_range(0, 9) < 8) ins[6:0] = ops[$urandom_range(0, 10)];
    if ($urandom_range(0, 3) != 0) ins[31:25] = f7s[$urandom_range(0, 3)];
    return ins;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hDEADBEEF;

    rst_i = 1'b1;
    repeat (2) begin @(posedge clk_i); #1; end
    chk_zero("reset");
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    run(32'hFFF00293, 0, 1, 0);
    chk("addi_class", op_class_o, 4'd8);
    chk("addi_imm", imm_o, 32'hFFFFFFFF);

    rf[2] = 32'd7;
    rf[3] = 32'd6;
    run(32'h023100B3, 0, 1, 0);
    chk("mul_illegal", illegal_o, !M_ON);

    run({12'h123, 5'd4, 3'b000, 5'd9, 7'h13}, 5, 1, 0);

    run({7'b0100000, 5'd3, 5'd2, 3'b000, 5'd1, 7'h33}, 5, 4, 6);

    for (int n = 0; n < 40; n++) begin
      for (int i = 1; i < 32; i++) rf[i] = $urandom;
      run(rand_instr(), $urandom_range(0, 2), $urandom_range(1, 3), 0);
    end

    instruction_i = rand_instr();
    decode_activate_i = 1'b1;
    @(posedge clk_i); #1;
    decode_activate_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    exp_perr = 1'b0;
    chk_zero("midreset");
    rst_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_i); #1;
      chk("post_reset_exec", execute_activate_o, 0);
      chk("post_reset_working", decode_working_info_o, 0);
    end

    run({20'hABCDE, 5'd7, 7'h37}, 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
